// File: rtl/sccpu_trace_pkg.sv
// Shared types and record layout for the SCCPU commit-trace buffer.
package sccpu_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } trace_state_e;

    localparam int REC_W    = 96;
    localparam int PC_LSB   = 64;
    localparam int INST_LSB = 32;
    localparam int ALU_LSB  = 0;

    function automatic logic [REC_W-1:0] pack_rec(input logic [31:0] pc,
                                                  input logic [31:0] inst,
                                                  input logic [31:0] alu);
        logic [REC_W-1:0] rec;
        rec                   = {REC_W{1'b0}};
        rec[PC_LSB   +: 32]   = pc;
        rec[INST_LSB +: 32]   = inst;
        rec[ALU_LSB  +: 32]   = alu;
        return rec;
    endfunction

endpackage

// File: rtl/sccpu_trace_fifo.sv
// Generic first-word-fall-through FIFO; level is kept apart from the pointers
// so that full and empty are exact without a wrap bit.
module sccpu_trace_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o,
    output logic [PTR_W:0]   level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   level_q;
    logic [PTR_W:0]   level_d;
    logic             empty_s;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign empty_s   = (level_q == {(PTR_W+1){1'b0}});
    assign full_o    = (level_q == (PTR_W+1)'(DEPTH));
    assign pop_ok_s  = pop_i && !empty_s;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok_s = push_i && (!full_o || pop_ok_s);
    assign valid_o   = !empty_s;
    assign level_o   = level_q;
    assign data_o    = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_s) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/sccpu_trace_buffer.sv
// Captures one commit record per cycle from the SCCPU while armed, with an
// optional stop-on-PC trigger and sticky drop accounting when the FIFO is full.
module sccpu_trace_buffer
    import sccpu_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [31:0]      PC,
    input  logic [31:0]      Inst,
    input  logic [31:0]      Alu_Result,
    input  logic             Arm,
    input  logic             Stop_En,
    input  logic [31:0]      Stop_Pc,
    input  logic             Trace_Ready,
    output logic             Trace_Valid,
    output logic [REC_W-1:0] Trace_Data,
    output logic [PTR_W:0]   Level,
    output logic             Overflow,
    output logic [CNT_W-1:0] Drop_Count,
    output logic [1:0]       State
);

    trace_state_e     state_q;
    trace_state_e     state_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             clear_s;
    logic             drop_s;

    assign pop_s  = Trace_Valid && Trace_Ready;
    assign drop_s = push_s && full_s && !pop_s;

    sccpu_trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk     (Clock),
        .rst_n   (Resetn),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (pack_rec(PC, Inst, Alu_Result)),
        .data_o  (Trace_Data),
        .valid_o (Trace_Valid),
        .full_o  (full_s),
        .level_o (Level)
    );

    // Arm restarts capture from IDLE or DONE; the arming cycle itself is not recorded.
    always_comb begin
        state_d = state_q;
        push_s  = 1'b0;
        clear_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Arm) begin
                    state_d = ST_CAPTURE;
                    clear_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_CAPTURE: begin
                push_s = 1'b1;
                if (Stop_En && (PC == Stop_Pc)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        if (clear_s) begin
            ovf_d = 1'b0;
            cnt_d = {CNT_W{1'b0}};
        end else if (drop_s) begin
            ovf_d = 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            ovf_d = ovf_q;
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            ovf_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Overflow   = ovf_q;
    assign Drop_Count = cnt_q;
    assign State      = state_q;

endmodule

// File: tb/tb_sccpu_trace_buffer.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal anchors, then a randomized soak.
module tb_sccpu_trace_buffer;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;
    localparam int CNT_W = 16;

    logic          Clock;
    logic          Resetn;
    logic [31:0]   PC, Inst, Alu_Result, Stop_Pc;
    logic          Arm, Stop_En, Trace_Ready;
    logic          Trace_Valid;
    logic [95:0]   Trace_Data;
    logic [PTR_W:0] Level;
    logic          Overflow;
    logic [CNT_W-1:0] Drop_Count;
    logic [1:0]    State;

    sccpu_trace_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .PC          (PC),
        .Inst        (Inst),
        .Alu_Result  (Alu_Result),
        .Arm         (Arm),
        .Stop_En     (Stop_En),
        .Stop_Pc     (Stop_Pc),
        .Trace_Ready (Trace_Ready),
        .Trace_Valid (Trace_Valid),
        .Trace_Data  (Trace_Data),
        .Level       (Level),
        .Overflow    (Overflow),
        .Drop_Count  (Drop_Count),
        .State       (State)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: 0=idle, 1=capture, 2=done
    logic [95:0] mq[$];
    int          m_state;
    bit          m_ovf;
    int          m_drop;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_state = 0;
        m_ovf   = 0;
        m_drop  = 0;
    endtask

    task automatic model_edge();
        bit pop;
        bit stop;
        pop  = (mq.size() > 0) && (Trace_Ready === 1'b1);
        stop = Stop_En && (PC == Stop_Pc);
        if (pop) void'(mq.pop_front());
        if (m_state == 1) begin
            if (mq.size() >= DEPTH) begin
                m_ovf = 1;
                if (m_drop < 65535) m_drop++;
            end else begin
                mq.push_back({PC, Inst, Alu_Result});
            end
        end
        if (m_state == 1) begin
            if (stop) m_state = 2;
        end else if (Arm) begin
            m_state = 1;
            m_ovf   = 0;
            m_drop  = 0;
        end
    endtask

    task automatic check_all();
        logic [95:0] exp_d;
        exp_d = (mq.size() > 0) ? mq[0] : 96'd0;
        chk("valid", 96'(Trace_Valid), 96'(mq.size() > 0));
        chk("data",  Trace_Data, exp_d);
        chk("level", 96'(Level), 96'(mq.size()));
        chk("overflow", 96'(Overflow), 96'(m_ovf));
        chk("drop_count", 96'(Drop_Count), 96'(m_drop));
        chk("state", 96'(State), 96'(m_state));
    endtask

    task automatic cyc();
        @(posedge Clock);
        model_edge();
        @(negedge Clock);
        check_all();
    endtask

    task automatic set_pc(input logic [31:0] pc);
        PC         = pc;
        Inst       = pc ^ 32'hA5A5_0000;
        Alu_Result = pc + 32'h0000_0100;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any edge.
    task automatic do_reset();
        #2;
        Resetn = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_level", 96'(Level), 96'd0);
        chk("async_valid", 96'(Trace_Valid), 96'd0);
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    initial begin
        Resetn = 1'b0;
        Arm = 1'b0; Stop_En = 1'b0; Stop_Pc = 32'd0; Trace_Ready = 1'b0;
        set_pc(32'd0);
        model_reset();
        @(negedge Clock);
        @(negedge Clock);
        check_all();
        chk("reset_state", 96'(State), 96'd0);
        Resetn = 1'b1;

        // 1: arm, then PCs 0,4,8 drained immediately
        Trace_Ready = 1'b1;
        Arm = 1'b1; set_pc(32'hFFFF_FFF0);
        cyc();
        chk("t1_arm_no_capture", 96'(Level), 96'd0);
        Arm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_pc(32'(i * 4));
            cyc();
            chk("t1_head_pc", 96'(Trace_Data[95:64]), 96'(i * 4));
            chk("t1_level_le1", 96'(Level <= 1), 96'd1);
        end
        do_reset();

        // 2: stop trigger at 0x0C
        Trace_Ready = 1'b0; Stop_En = 1'b1; Stop_Pc = 32'h0000_000C;
        Arm = 1'b1; set_pc(32'hFFFF_FFF0);
        cyc();
        Arm = 1'b0;
        for (int i = 0; i < 7; i++) begin
            set_pc(32'(i * 4));
            cyc();
        end
        chk("t2_level", 96'(Level), 96'd4);
        chk("t2_state_done", 96'(State), 96'd2);
        chk("t2_head_pc", 96'(Trace_Data[95:64]), 96'd0);
        do_reset();

        // 3: 20 captures into a 16-deep FIFO, stopping on the 20th PC
        Stop_En = 1'b1; Stop_Pc = 32'h0000_004C;
        Arm = 1'b1;
        cyc();
        Arm = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_pc(32'(i * 4));
            cyc();
        end
        chk("t3_level", 96'(Level), 96'd16);
        chk("t3_overflow", 96'(Overflow), 96'd1);
        chk("t3_drop", 96'(Drop_Count), 96'd4);
        chk("t3_state_done", 96'(State), 96'd2);

        // 6: re-arm from DONE clears accounting, old contents remain at head
        Stop_En = 1'b0; Arm = 1'b1; set_pc(32'h0000_1000);
        cyc();
        Arm = 1'b0;
        chk("t6_state_capture", 96'(State), 96'd1);
        chk("t6_overflow_clr", 96'(Overflow), 96'd0);
        chk("t6_drop_clr", 96'(Drop_Count), 96'd0);
        chk("t6_old_head", 96'(Trace_Data[95:64]), 96'd0);

        // 4: full with Ready=1 during capture: level holds, no drops, head advances
        Trace_Ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_pc(32'h0000_1000 + 32'(i * 4));
            cyc();
            chk("t4_head_adv", 96'(Trace_Data[95:64]), 96'((i + 1) * 4));
        end
        chk("t4_level", 96'(Level), 96'd16);
        chk("t4_drop", 96'(Drop_Count), 96'd0);
        do_reset();

        // 5: reset mid-capture with 7 entries held
        Trace_Ready = 1'b0;
        Arm = 1'b1;
        cyc();
        Arm = 1'b0;
        for (int i = 0; i < 7; i++) begin
            set_pc(32'(i * 4));
            cyc();
        end
        chk("t5_level7", 96'(Level), 96'd7);
        do_reset();
        chk("t5_state_idle", 96'(State), 96'd0);

        // Randomized soak
        begin
            int rdy_pct;
            rdy_pct = 50;
            for (int n = 0; n < 3000; n++) begin
                if ((n % 200) == 0) rdy_pct = int'($urandom_range(0, 100));
                Arm         = ($urandom_range(0, 7) == 0);
                Stop_En     = $urandom_range(0, 1) == 1;
                Stop_Pc     = 32'($urandom_range(0, 15) * 4);
                Trace_Ready = (int'($urandom_range(0, 99)) < rdy_pct);
                PC          = 32'($urandom_range(0, 15) * 4);
                Inst        = $urandom();
                Alu_Result  = $urandom();
                cyc();
                if ($urandom_range(0, 299) == 0) do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sccpu_trace_buffer.md
Name: sccpu_trace_buffer

Overview:
- Downstream consumer of the single-cycle CPU's architectural outputs (PC, Inst, Alu_Result).
- Captures one 96-bit commit record per clock into a FIFO and drains it over a valid/ready port to a debug/UART host.
- Supports arming, an optional stop-on-PC trigger, and overflow accounting.
- Sits beside the SCCPU top in simulation and FPGA debug builds.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2, minimum 2.
- PTR_W, 4, log2(DEPTH).
- CNT_W, 16, width of the dropped-record counter.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Resetn  input  1  asynchronous active-low reset.
- PC  input  32  CPU program counter for the current cycle.
- Inst  input  32  CPU instruction for the current cycle.
- Alu_Result  input  32  CPU ALU result for the current cycle.
- Arm  input  1  start capture; level-sampled on the edge.
- Stop_En  input  1  enables the stop-on-PC trigger.
- Stop_Pc  input  32  trigger address.
- Trace_Ready  input  1  consumer accepts the head record.
- Trace_Valid  output  1  head record available.
- Trace_Data  output  96  head record: [95:64]=PC, [63:32]=Inst, [31:0]=Alu_Result.
- Level  output  PTR_W+1  current FIFO occupancy, 0..DEPTH.
- Overflow  output  1  sticky: at least one record was dropped.
- Drop_Count  output  CNT_W  number of dropped records; saturates at all-ones.
- State  output  2  0=IDLE, 1=CAPTURE, 2=DONE.

Behaviour:
- Reset (Resetn low, asynchronous, any time including mid-capture or mid-drain):
  - Pointers 0, Level 0, Trace_Valid 0, Trace_Data 0, Overflow 0, Drop_Count 0, State IDLE.
  - FIFO contents are discarded.
- IDLE:
  - No capture.
  - Arm=1 at an edge -> CAPTURE. The Arm cycle itself is not captured.
  - Overflow and Drop_Count are cleared on that edge.
- CAPTURE:
  - Every edge pushes {PC, Inst, Alu_Result} sampled at that edge.
  - Arm is ignored.
  - If Stop_En=1 and PC==Stop_Pc at an edge, that record is pushed (subject to the full rules below) and State -> DONE on the same edge.
- DONE:
  - No pushes.
  - Arm=1 -> CAPTURE, clearing Overflow and Drop_Count. FIFO contents are kept.
- Draining:
  - Independent of State.
  - Pop occurs when Trace_Valid && Trace_Ready at an edge.
- Output timing:
  - First-word-fall-through output.
  - A record pushed at edge N is visible on Trace_Valid/Trace_Data after edge N; latency is 1 cycle.
  - Trace_Data is 0 whenever Trace_Valid=0.
  - Trace_Data is stable while Trace_Valid=1 and Trace_Ready=0.
- Full:
  - A push when Level==DEPTH with no simultaneous pop is dropped.
  - On a drop: Overflow<=1 and Drop_Count increments, saturating.
  - Push and pop in the same cycle while full: both succeed and Level stays DEPTH.
- Empty:
  - No pop is possible.
  - A push while empty makes Trace_Valid=1 the next cycle.
- Pointer wrap:
  - Pointers are PTR_W bits and wrap modulo DEPTH.
  - Level is tracked separately and is exact at 0 and DEPTH.
- Level update: Level += push_accepted - pop.
- State encoding 3 is unreachable; if entered, the block returns to IDLE next edge.

Decomposition:
- Shared package sccpu_trace_pkg:
  - State encodings (ST_IDLE, ST_CAPTURE, ST_DONE).
  - REC_W=96 and field offsets (PC_LSB=64, INST_LSB=32, ALU_LSB=0).
- Natural sub-module sccpu_trace_fifo:
  - Generic FWFT synchronous FIFO with push/pop/full/empty/level, parameterised by width and depth.
  - The top holds the FSM, the trigger compare, and the drop accounting.

Test Plan:
- Reset, then Arm pulse at cycle 1, PC=0,4,8 on the following edges, Trace_Ready=1 -> records with PC 0,4,8 appear in order, each 1 cycle after its capture; Level never exceeds 1.
- Stop_En=1, Stop_Pc=0x0C, PC incrementing by 4 from 0, Trace_Ready=0 -> 4 records captured (0x0 to 0xC); State=DONE; Level=4; further PCs not captured.
- DEPTH=16, Trace_Ready=0, 20 capture cycles -> Level=16, Overflow=1, Drop_Count=4; drained records are the first 16 PCs.
- Full FIFO with Trace_Ready=1 during capture -> Level holds at 16, Drop_Count unchanged, the head advances every cycle.
- Resetn pulsed low mid-capture with Level=7 -> immediately Level=0, Trace_Valid=0, State=IDLE, Drop_Count=0, without waiting for a clock edge.
- In DONE with Overflow=1, Drop_Count=4, assert Arm -> State=CAPTURE, Overflow=0, Drop_Count=0, old FIFO contents drain first.
